ctrl_pipe: RTL and testbench

Parametrised control-path pipeline for the RISC-V core. It takes the decoded control bundle produced in Decode and carries it through `STAGES` registered stages (stage 0 = Execute … stage `STAGES-1` = Writeback). It adds what bare decode lacks:
- load-use stall detection
- branch/jump squash
- operand-forwarding selection
- a halt-drain state machine that retires everything older than `hlt` before stopping the core

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/fwd_sel.sv | 25 ++
 rtl/ctrl_pipe.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the control-path pipeline: decoded bundle, bubble constant, halt FSM states.
package ctrl_pkg;

    localparam int RA_W_DEF = 5;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_write;
        logic [2:0]          mem_size;
        logic [1:0]          alu_srcA;
        logic [1:0]          alu_srcB;
        logic [3:0]          alu_control;
        logic                jump;
        logic                jump_src;
        logic                branch;
        logic                inv_branch;
        logic                alu_src_is_zero;
        logic                hlt;
        logic [RA_W_DEF-1:0] rd;
        logic [RA_W_DEF-1:0] rs1;
        logic [RA_W_DEF-1:0] rs2;
    } ctrl_t;

    // All-zero bundle: a bubble never writes, branches or halts.
    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } haltState_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source search for one stage-0 operand: youngest valid producer in stages 1..STAGES-1.
module fwd_sel #(
    parameter int STAGES = 3,
    parameter int RA_W   = 5,
    parameter int FW_W   = $clog2(STAGES)
) (
    input  logic                          en,
    input  logic [STAGES-1:1]             prodValid,
    input  logic [STAGES-1:1][RA_W-1:0]   prodRd,
    input  logic [RA_W-1:0]               srcReg,
    output logic [FW_W-1:0]               sel
);

    // Scan oldest to youngest so the lowest matching stage is the one that sticks.
    always_comb begin
        sel = '0;
        if (en) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                if (prodValid[k] && (prodRd[k] != '0) && (prodRd[k] == srcReg))
                    sel = FW_W'(k);
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-path pipeline after Decode: stage registers, load-use stall, redirect squash,
// operand-forward selection and a halt-drain FSM.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            d_valid,
    input  ctrl_t                           d_ctrl,
    input  logic                            ext_stall,
    input  logic                            redirect,
    output logic [STAGES-1:0]               st_valid,
    output ctrl_t [STAGES-1:0]              st_ctrl,
    output logic                            stall_fd,
    output logic                            flush_fd,
    output logic [$clog2(STAGES)-1:0]       fwd_a,
    output logic [$clog2(STAGES)-1:0]       fwd_b,
    output logic                            halted
);

    localparam int FW_W = $clog2(STAGES);

    haltState_t state, stateNxt;
    logic       loadUse;
    logic       advance;
    logic       clearAll;
    logic       s0Valid;
    ctrl_t      s0Ctrl;

    logic [STAGES-1:1]           prodValid;
    logic [STAGES-1:1][RA_W-1:0] prodRd;
    logic [1:0][RA_W-1:0]        srcRegs;
    logic [1:0][FW_W-1:0]        fwdSel;

    // A load still too young to forward blocks a dependent instruction in Decode.
    always_comb begin
        loadUse = 1'b0;
        if (d_valid) begin
            for (int k = 0; k <= STAGES - 3; k++) begin
                if (st_valid[k] && st_ctrl[k].mem_to_reg && (st_ctrl[k].rd != '0) &&
                    ((st_ctrl[k].rd == d_ctrl.rs1) || (st_ctrl[k].rd == d_ctrl.rs2)))
                    loadUse = 1'b1;
            end
        end
    end

    // Per-cycle arbitration: freeze, halted, drain, redirect, load-use, normal issue.
    always_comb begin
        stateNxt = state;
        stall_fd = 1'b0;
        flush_fd = 1'b0;
        advance  = 1'b1;
        clearAll = 1'b0;
        s0Valid  = d_valid;
        s0Ctrl   = d_valid ? d_ctrl : CTRL_NOP;
        if (ext_stall) begin
            advance  = 1'b0;
            stall_fd = 1'b1;
        end else begin
            case (state)
                HALTED: begin
                    stall_fd = 1'b1;
                    clearAll = 1'b1;
                end
                DRAIN: begin
                    stall_fd = 1'b1;
                    s0Valid  = 1'b0;
                    s0Ctrl   = CTRL_NOP;
                    if (st_valid[STAGES-1] && st_ctrl[STAGES-1].hlt)
                        stateNxt = HALTED;
                end
                default: begin
                    if (redirect && st_valid[0]) begin
                        flush_fd = 1'b1;
                        s0Valid  = 1'b0;
                        s0Ctrl   = CTRL_NOP;
                    end else if (loadUse) begin
                        stall_fd = 1'b1;
                        s0Valid  = 1'b0;
                        s0Ctrl   = CTRL_NOP;
                    end else if (d_valid && d_ctrl.hlt) begin
                        stateNxt = DRAIN;
                    end
                end
            endcase
        end
    end

    // Halt FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= stateNxt;
    end

    // Stage registers shift one step per non-frozen edge; stage 0 takes Decode or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_ctrl  <= '0;
        end else if (clearAll) begin
            st_valid <= '0;
            st_ctrl  <= '0;
        end else if (advance) begin
            st_valid <= {st_valid[STAGES-2:0], s0Valid};
            st_ctrl  <= {st_ctrl[STAGES-2:0], s0Ctrl};
        end
    end

    // Producer view of stages 1..STAGES-1 for the forwarding search.
    generate
        for (genvar k = 1; k < STAGES; k++) begin : gProd
            assign prodValid[k] = st_valid[k] && st_ctrl[k].reg_write;
            assign prodRd[k]    = st_ctrl[k].rd;
        end
    endgenerate

    assign srcRegs[0] = st_ctrl[0].rs1;
    assign srcRegs[1] = st_ctrl[0].rs2;

    // One search per source operand.
    generate
        for (genvar g = 0; g < 2; g++) begin : gFwd
            fwd_sel #(.STAGES(STAGES), .RA_W(RA_W), .FW_W(FW_W)) uSel (
                .en        (st_valid[0]),
                .prodValid (prodValid),
                .prodRd    (prodRd),
                .srcReg    (srcRegs[g]),
                .sel       (fwdSel[g])
            );
        end
    endgenerate

    assign fwd_a  = fwdSel[0];
    assign fwd_b  = fwdSel[1];
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: vector table plus halt, reset and deep-pipe load-use sequences.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  dv = 1'b0;
    ctrl_t dc = CTRL_NOP;
    logic  es = 1'b0;
    logic  rdr = 1'b0;

    logic [2:0]  val3;
    ctrl_t [2:0] ctl3;
    logic        stall3, flush3, halt3;
    logic [1:0]  fa3, fb3;

    logic [4:0]  val5;
    ctrl_t [4:0] ctl5;
    logic        stall5, flush5, halt5;
    logic [2:0]  fa5, fb5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .d_valid(dv), .d_ctrl(dc), .ext_stall(es), .redirect(rdr),
        .st_valid(val3), .st_ctrl(ctl3), .stall_fd(stall3), .flush_fd(flush3),
        .fwd_a(fa3), .fwd_b(fb3), .halted(halt3)
    );

    ctrl_pipe #(.STAGES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .d_valid(dv), .d_ctrl(dc), .ext_stall(es), .redirect(rdr),
        .st_valid(val5), .st_ctrl(ctl5), .stall_fd(stall5), .flush_fd(flush5),
        .fwd_a(fa5), .fwd_b(fb5), .halted(halt5)
    );

    typedef struct {
        logic       v;
        ctrl_t      c;
        logic       s;
        logic       r;
        logic       eStall;
        logic       eFlush;
        logic [1:0] eFa;
        logic [1:0] eFb;
        logic [2:0] eVal;
        logic [4:0] eRd2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic ctrl_t mk(input logic rw, input logic m2r, input logic h,
                                 input int rd, input int r1, input int r2);
        ctrl_t c;
        c = CTRL_NOP;
        c.reg_write  = rw;
        c.mem_to_reg = m2r;
        c.hlt        = h;
        c.rd         = RA_W_DEF'(rd);
        c.rs1        = RA_W_DEF'(r1);
        c.rs2        = RA_W_DEF'(r2);
        return c;
    endfunction

    function automatic ctrl_t alu(input int rd, input int r1, input int r2);
        return mk(1'b1, 1'b0, 1'b0, rd, r1, r2);
    endfunction

    function automatic ctrl_t ld(input int rd, input int r1);
        return mk(1'b1, 1'b1, 1'b0, rd, r1, 0);
    endfunction

    task automatic drive(input logic v, input ctrl_t c, input logic s, input logic r);
        dv = v; dc = c; es = s; rdr = r;
    endtask

    task automatic add(input logic v, input ctrl_t c, input logic s, input logic r,
                       input logic eSt, input logic eFl, input logic [1:0] eA, input logic [1:0] eB,
                       input logic [2:0] eV, input logic [4:0] eR);
        tbl.push_back('{v, c, s, r, eSt, eFl, eA, eB, eV, eR});
    endtask

    task automatic pulseReset(input string nm);
        @(negedge clk);
        drive(1'b0, CTRL_NOP, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk({nm, "_halted"}, halt3, 0);
        chk({nm, "_valid"}, val3, 0);
        chk({nm, "_stall"}, stall3, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Capture a hlt, keep offering younger instructions, optionally freeze two cycles.
    task automatic runHalt(input string nm, input int frzA, input int frzB);
        int   eff;
        logic prevEs;
        @(negedge clk);
        drive(1'b1, mk(1'b0, 1'b0, 1'b1, 0, 0, 0), 1'b0, 1'b0);
        #1;
        chk({nm, "_pre_stall"}, stall3, 0);
        chk({nm, "_pre_halted"}, halt3, 0);
        eff = 0;
        prevEs = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (!prevEs) eff++;
            prevEs = (n == frzA) || (n == frzB);
            drive(1'b1, alu(1, 2, 3), prevEs, n == 1);
            #1;
            chk($sformatf("%s_n%0d_stall", nm, n), stall3, 1);
            chk($sformatf("%s_n%0d_flush", nm, n), flush3, 0);
            chk($sformatf("%s_n%0d_halted", nm, n), halt3, (eff >= 4) ? 1 : 0);
            chk($sformatf("%s_n%0d_s0", nm, n), val3[0], (eff == 1) ? 1 : 0);
            chk($sformatf("%s_n%0d_hlt_s2", nm, n), val3[2] && ctl3[2].hlt, (eff == 3) ? 1 : 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   cnt3, cnt5;
        logic got3, got5, pend3, pend5;
        vec_t t;

        // Independent ALU ops, back-to-back and one-gap forwarding, youngest-wins.
        add(1, alu(1, 2, 3),   0, 0, 0, 0, 0, 0, 3'b000, 0);
        add(1, alu(4, 2, 3),   0, 0, 0, 0, 0, 0, 3'b001, 0);
        add(1, alu(9, 10, 11), 0, 0, 0, 0, 0, 0, 3'b011, 0);
        add(1, alu(5, 6, 7),   0, 0, 0, 0, 0, 0, 3'b111, 1);
        add(1, alu(6, 5, 5),   0, 0, 0, 0, 0, 0, 3'b111, 4);
        add(0, CTRL_NOP,       0, 0, 0, 0, 1, 1, 3'b111, 9);
        add(1, alu(12, 13, 13),0, 0, 0, 0, 0, 0, 3'b110, 5);
        add(1, alu(20, 1, 1),  0, 0, 0, 0, 0, 0, 3'b101, 6);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b011, 0);
        add(1, alu(21, 20, 3), 0, 0, 0, 0, 0, 0, 3'b110, 12);
        add(0, CTRL_NOP,       0, 0, 0, 0, 2, 0, 3'b101, 20);
        add(1, alu(22, 1, 1),  0, 0, 0, 0, 0, 0, 3'b010, 0);
        add(1, alu(22, 1, 1),  0, 0, 0, 0, 0, 0, 3'b101, 21);
        add(1, alu(23, 22, 22),0, 0, 0, 0, 0, 0, 3'b011, 0);
        add(0, CTRL_NOP,       0, 0, 0, 0, 1, 1, 3'b111, 22);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b110, 22);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b100, 23);
        // Load-use with x7, then a load to x0 that must not stall or forward.
        add(1, ld(7, 1),       0, 0, 0, 0, 0, 0, 3'b000, 0);
        add(1, alu(8, 7, 1),   0, 0, 1, 0, 0, 0, 3'b001, 0);
        add(1, alu(8, 7, 1),   0, 0, 0, 0, 0, 0, 3'b010, 0);
        add(0, CTRL_NOP,       0, 0, 0, 0, 2, 0, 3'b101, 7);
        add(1, ld(0, 1),       0, 0, 0, 0, 0, 0, 3'b010, 0);
        add(1, alu(8, 0, 0),   0, 0, 0, 0, 0, 0, 3'b101, 8);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b011, 0);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b110, 0);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b100, 8);
        // Redirect beats load-use; redirect with empty stage 0; frozen cycle ignores everything.
        add(1, ld(7, 1),       0, 0, 0, 0, 0, 0, 3'b000, 0);
        add(1, alu(8, 7, 1),   0, 1, 0, 1, 0, 0, 3'b001, 0);
        add(0, CTRL_NOP,       0, 1, 0, 0, 0, 0, 3'b010, 0);
        add(1, alu(9, 1, 1),   1, 1, 1, 0, 0, 0, 3'b100, 7);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b100, 7);
        add(0, CTRL_NOP,       0, 0, 0, 0, 0, 0, 3'b000, 0);

        // Reset state
        drive(1'b0, CTRL_NOP, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", val3, 0);
        chk("rst_ctrl_zero", (ctl3 == '0) ? 1 : 0, 1);
        chk("rst_halted", halt3, 0);
        chk("rst_stall", stall3, 0);
        chk("rst_flush", flush3, 0);
        chk("rst_fwd_a", fa3, 0);
        chk("rst_valid5", val5, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            t = tbl[i];
            @(negedge clk);
            drive(t.v, t.c, t.s, t.r);
            #1;
            chk($sformatf("r%0d_stall", i), stall3, t.eStall);
            chk($sformatf("r%0d_flush", i), flush3, t.eFlush);
            chk($sformatf("r%0d_fwd_a", i), fa3, t.eFa);
            chk($sformatf("r%0d_fwd_b", i), fb3, t.eFb);
            chk($sformatf("r%0d_valid", i), val3, t.eVal);
            chk($sformatf("r%0d_rd2", i), ctl3[2].rd, t.eRd2);
            chk($sformatf("r%0d_halted", i), halt3, 0);
        end

        runHalt("halt", 0, 0);
        pulseReset("rst_halted_state");
        runHalt("haltfrz", 2, 3);
        pulseReset("rst_halted_state2");

        // Reset in the middle of a drain, then normal flow.
        @(negedge clk);
        drive(1'b1, mk(1'b0, 1'b0, 1'b1, 0, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, alu(1, 2, 3), 1'b0, 1'b0);
        #1;
        chk("middrain_stall", stall3, 1);
        chk("middrain_valid", val3, 3'b001);
        #1 rst_n = 1'b0;
        #1;
        chk("middrain_rst_valid", val3, 0);
        chk("middrain_rst_halted", halt3, 0);
        chk("middrain_rst_stall", stall3, 0);
        chk("middrain_rst_flush", flush3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, alu(3, 4, 5), 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, CTRL_NOP, 1'b0, 1'b0);
        end
        #1;
        chk("postrst_valid", val3, 3'b100);
        chk("postrst_rd2", ctl3[2].rd, 3);
        chk("postrst_stall", stall3, 0);

        // Load-use stall length at 3 and 5 stages, then forwarding from the last stage.
        pulseReset("rst_lu");
        @(negedge clk);
        drive(1'b1, ld(7, 1), 1'b0, 1'b0);
        cnt3 = 0; cnt5 = 0;
        got3 = 0; got5 = 0; pend3 = 0; pend5 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b1, alu(8, 7, 1), 1'b0, 1'b0);
            #1;
            if (pend3) begin
                chk("lu3_fwd_a", fa3, 2);
                chk("lu3_fwd_b", fb3, 0);
                pend3 = 0;
            end
            if (pend5) begin
                chk("lu5_fwd_a", fa5, 4);
                chk("lu5_fwd_b", fb5, 0);
                pend5 = 0;
            end
            if (stall3) cnt3++;
            else if (!got3) begin got3 = 1; pend3 = 1; end
            if (stall5) cnt5++;
            else if (!got5) begin got5 = 1; pend5 = 1; end
        end
        chk("lu3_stall_cycles", cnt3, 1);
        chk("lu5_stall_cycles", cnt5, 3);
        chk("lu5_flush", flush5, 0);
        chk("lu5_halted", halt5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
